// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the SRAM controller.
//   state_t : controller FSM states
//   op_t    : latched operation kind
//   last_beat() : index of the final halfword beat for an operation
package sram_pkg;
   typedef enum logic [2:0] {IDLE, BEAT, NEXT, DONE, POST} state_t;
   typedef enum logic {OP_RD, OP_WR} op_t;
   localparam int RD_BEATS = 4;
   localparam int WR_BEATS = 2;
   localparam int SRAM_DW  = 16;
   function automatic logic [1:0] last_beat(input op_t op);
      return (op == OP_WR) ? 2'(WR_BEATS - 1) : 2'(RD_BEATS - 1);
   endfunction
endpackage

// File: rtl/sram_beat_timer.sv
// sram_beat_timer: counts cycles within one SRAM halfword beat.
//   clk, rst    : clock, async active-high reset
//   active      : high while the controller is in a beat; low restarts the count
//   beat_first  : first cycle of the beat
//   we_window   : first WAIT_STATES cycles of the beat (write strobe window)
//   beat_last   : final cycle of the beat (capture / hold cycle)
module sram_beat_timer #(
   parameter int WAIT_STATES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   output logic beat_first,
   output logic we_window,
   output logic beat_last
);
   logic [2:0] cnt_q, cnt_d;
   always_comb cnt_d = (active && !beat_last) ? cnt_q + 3'd1 : 3'd0;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= 3'd0;
      else     cnt_q <= cnt_d;
   assign beat_first = active && (cnt_q == 3'd0);
   assign we_window  = active && (cnt_q < 3'(WAIT_STATES));
   assign beat_last  = active && (cnt_q == 3'(WAIT_STATES));
endmodule

// File: rtl/sram_controller.sv
// sram_controller: sequences a 16-bit async SRAM for cache refills (4 halfword reads)
// and stores (2 halfword writes) with programmable wait states.
//   clk, rst            : clock, async active-high reset
//   read_en, write_en   : refill / store requests, held until ready (write wins a tie)
//   address, write_data : byte address and store data, latched on acceptance
//   read_data           : refilled line {hw3,hw2,hw1,hw0}
//   ready               : one-cycle completion pulse
//   SRAM_*              : external SRAM bus and active-low strobes
// Build option: define SRAM_POSTED_WRITE_EN to acknowledge writes in the cycle after
// acceptance and finish their beats in the background.
module sram_controller
   import sram_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_W      = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 read_en,
   input  logic                 write_en,
   input  logic [31:0]          address,
   input  logic [31:0]          write_data,
   output logic [63:0]          read_data,
   output logic                 ready,
   inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
   output logic [ADDR_W-1:0]    SRAM_ADDR,
   output logic                 SRAM_WE_N,
   output logic                 SRAM_OE_N,
   output logic                 SRAM_CE_N,
   output logic                 SRAM_UB_N,
   output logic                 SRAM_LB_N
);
`ifdef SRAM_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif
   state_t              state_q, state_d;
   op_t                 op_q, op_d;
   logic [1:0]          beat_q, beat_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [63:0]         rdata_q, rdata_d;
   logic                beat_first, we_window, beat_last;
   logic                in_beat, is_wr;
   logic                unused_addr;
   assign unused_addr = ^{address[31:ADDR_W+1], address[1:0]};
   assign in_beat = (state_q == BEAT);
   assign is_wr   = (op_q == OP_WR);
   sram_beat_timer #(.WAIT_STATES(WAIT_STATES)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .active     (in_beat),
      .beat_first (beat_first),
      .we_window  (we_window),
      .beat_last  (beat_last)
   );
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      beat_d  = beat_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (write_en || read_en) begin
            state_d = BEAT;
            beat_d  = 2'd0;
            op_d    = write_en ? OP_WR : OP_RD;
            wdata_d = write_data;
            addr_d  = write_en ? {address[ADDR_W:2], 1'b0} : {address[ADDR_W:3], 2'b00};
         end
         BEAT: if (beat_last) begin
            if (!is_wr) rdata_d[SRAM_DW*beat_q +: SRAM_DW] = SRAM_DQ;
            // posted writes already acknowledged, so they retire without a second ready
            state_d = (beat_q != last_beat(op_q)) ? NEXT : (POSTED && is_wr) ? POST : DONE;
         end
         NEXT: begin
            beat_d  = beat_q + 2'd1;
            state_d = BEAT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_RD;
         beat_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   assign ready     = (state_q == DONE) || (POSTED && in_beat && is_wr && beat_q == 2'd0 && beat_first);
   assign read_data = rdata_q;
   assign SRAM_ADDR = addr_q + ADDR_W'(beat_q);
   assign SRAM_CE_N = !in_beat;
   assign SRAM_OE_N = !(in_beat && !is_wr);
   assign SRAM_WE_N = !(in_beat && is_wr && we_window);
   assign SRAM_UB_N = SRAM_CE_N;
   assign SRAM_LB_N = SRAM_CE_N;
   assign SRAM_DQ   = (in_beat && is_wr) ? (beat_q[0] ? wdata_q[31:16] : wdata_q[15:0]) : 'z;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: self-checking bench for sram_controller with a behavioural SRAM.
module tb_sram_controller;
   localparam int WS      = 1;
   localparam int RD_LAT  = 4*(WS+1)+3+1;
   localparam int WR_FULL = 2*(WS+1)+1+1;
`ifdef SRAM_POSTED_WRITE_EN
   localparam int WR_LAT = 1;
   localparam bit POSTED = 1'b1;
`else
   localparam int WR_LAT = WR_FULL;
   localparam bit POSTED = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1;
   logic        read_en = 1'b0, write_en = 1'b0;
   logic [31:0] address = '0, write_data = '0;
   logic [63:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
   logic [15:0] mem [0:262143];
   typedef struct { logic [63:0] rdata; int lat; } exp_t;
   typedef struct {
      string name; bit wr; bit rd; logic [31:0] addr; logic [31:0] wdata;
      logic [17:0] base; logic [63:0] exp_rd;
   } vec_t;
   exp_t        exp_q[$];
   vec_t        vecs[6];
   logic [17:0] alog[$];
   int          total = 0, bad = 0, cyc = 0, we_cnt = 0, last_we = 0, first_oe = -1;
   sram_controller #(.WAIT_STATES(WS), .ADDR_W(18)) dut (
      .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
      .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
      .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
   );
   always #5 clk = ~clk;
   assign sram_dq = (sram_oe_n === 1'b0 && sram_ce_n === 1'b0) ? mem[sram_addr] : 16'hzzzz;
   always @(posedge clk)
      if (sram_we_n === 1'b0 && sram_ce_n === 1'b0) mem[sram_addr] = sram_dq;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (sram_we_n === 1'b0) begin
         we_cnt++;
         last_we = cyc;
      end
      if (sram_oe_n === 1'b0) begin
         if (first_oe < 0) first_oe = cyc;
         if (alog.size() == 0 || alog[$] !== sram_addr) alog.push_back(sram_addr);
      end
   endtask
   task automatic do_op(input vec_t v);
      exp_t e;
      int   n;
      alog.delete();
      we_cnt     = 0;
      write_en   = v.wr;
      read_en    = v.rd;
      address    = v.addr;
      write_data = v.wdata;
      exp_q.push_back('{v.exp_rd, v.wr ? WR_LAT : RD_LAT});
      n = 0;
      do begin tick(); n++; end while (ready !== 1'b1 && n < 60);
      write_en = 1'b0;
      read_en  = 1'b0;
      chk({v.name, "_ready"}, 64'(ready), 64'd1);
      e = exp_q.pop_front();
      chk({v.name, "_lat"}, 64'(n), 64'(e.lat));
      chk({v.name, "_rdata"}, read_data, e.rdata);
      repeat ((POSTED && v.wr) ? 6 : 1) tick();
      if (v.wr) begin
         chk({v.name, "_we_cycles"}, 64'(we_cnt), 64'(2*WS));
         chk({v.name, "_no_reads"}, 64'(alog.size()), 64'd0);
      end else begin
         chk({v.name, "_nreads"}, 64'(alog.size()), 64'd4);
         for (int i = 0; i < alog.size() && i < 4; i++)
            chk({v.name, "_addr"}, 64'(alog[i]), 64'(v.base + 18'(i)));
      end
   endtask
   initial begin
      int n, m;
      vecs[0] = '{"rd_line",   1'b0, 1'b1, 32'h0000_0108, 32'h0,           18'h00084, 64'h4444_3333_2222_1111};
      vecs[1] = '{"wr_store",  1'b1, 1'b0, 32'h0000_0014, 32'hDEAD_BEEF,   18'h0000A, 64'h4444_3333_2222_1111};
      vecs[2] = '{"rd_after",  1'b0, 1'b1, 32'h0000_0010, 32'h0,           18'h00008, 64'hDEAD_BEEF_0909_0808};
      vecs[3] = '{"wr_low",    1'b1, 1'b0, 32'h0000_0002, 32'h1234_5678,   18'h00000, 64'hDEAD_BEEF_0909_0808};
      vecs[4] = '{"wr_tie",    1'b1, 1'b1, 32'hFFFF_FFF8, 32'hCAFE_F00D,   18'h3FFFC, 64'hDEAD_BEEF_0909_0808};
      vecs[5] = '{"rd_top",    1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0,           18'h3FFFC, 64'hFFFF_EEEE_CAFE_F00D};
      mem[18'h84] = 16'h1111; mem[18'h85] = 16'h2222; mem[18'h86] = 16'h3333; mem[18'h87] = 16'h4444;
      mem[18'h08] = 16'h0808; mem[18'h09] = 16'h0909;
      mem[18'h3FFFE] = 16'hEEEE; mem[18'h3FFFF] = 16'hFFFF;
      mem[18'h22] = 16'h2222; mem[18'h23] = 16'h2323;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_rdata", read_data, 64'd0);
      chk("rst_addr", 64'(sram_addr), 64'd0);
      chk("rst_strobes", 64'({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}), 64'h1F);
      chk("rst_dq_z", 64'(sram_dq === 16'hzzzz), 64'd1);
      read_en = 1'b1;
      address = 32'h0000_0108;
      repeat (2*(WS+1)+2+1) tick();
      chk("mid_rd_beat2_addr", 64'(sram_addr), 64'h86);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_strobes", 64'({sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}), 64'h1F);
      chk("mid_rst_dq_z", 64'(sram_dq === 16'hzzzz), 64'd1);
      chk("mid_rst_ready", 64'(ready), 64'd0);
      read_en = 1'b0;
      tick();
      rst = 1'b0;
      chk("mid_rst_rdata", read_data, 64'd0);
      for (int i = 0; i < 6; i++) do_op(vecs[i]);
      chk("mem_a", 64'(mem[18'h0A]), 64'hBEEF);
      chk("mem_b", 64'(mem[18'h0B]), 64'hDEAD);
      chk("mem_0", 64'(mem[18'h00]), 64'h5678);
      chk("mem_1", 64'(mem[18'h01]), 64'h1234);
      read_en = 1'b1;
      address = 32'h0000_0108;
      n = 0;
      do begin tick(); n++; end while (ready !== 1'b1 && n < 60);
      chk("held_first_lat", 64'(n), 64'(RD_LAT));
      tick();
      chk("held_pulse_width", 64'(ready), 64'd0);
      tick();
      chk("held_restart", 64'(sram_ce_n), 64'd0);
      m = 2;
      while (ready !== 1'b1 && m < 60) begin tick(); m++; end
      chk("held_second_gap", 64'(m), 64'(RD_LAT+1));
      read_en = 1'b0;
      chk("held_rdata", read_data, 64'h4444_3333_2222_1111);
      tick();
`ifdef SRAM_POSTED_WRITE_EN
      alog.delete();
      first_oe   = -1;
      last_we    = 0;
      n          = 0;
      write_en   = 1'b1;
      address    = 32'h0000_0040;
      write_data = 32'hAAAA_5555;
      do begin tick(); n++; end while (ready !== 1'b1 && n < 60);
      chk("pw_ack_lat", 64'(n), 64'd1);
      write_en = 1'b0;
      read_en  = 1'b1;
      do begin tick(); n++; end while (ready !== 1'b1 && n < 80);
      read_en = 1'b0;
      chk("pw_rd_lat", 64'(n), 64'(WR_FULL+1+RD_LAT));
      chk("pw_rd_data", read_data, 64'h2323_2222_AAAA_5555);
      chk("pw_order", 64'(first_oe > last_we), 64'd1);
      chk("pw_rd_base", (alog.size() > 0) ? 64'(alog[0]) : 64'hFFFF, 64'h20);
      tick();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
